// File: rtl/clkdiv_gen_pkg.sv
// Shared definitions for the clkdiv_gen divider: FSM state encoding, minimum divisor,
// and the saturating debug-counter increment.
package clkdiv_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } clkdiv_state_e;

    localparam int CLKDIV_MIN_DIV = 32'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hffff) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clkdiv_gen_if.sv
// Divisor configuration handshake for clkdiv_gen: a new divisor is taken when
// cfg_valid and cfg_ready are both high on a clk edge.
interface clkdiv_gen_if #(
    parameter int W = 32'd8
) ();
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;

    modport master (output cfg_valid, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clkdiv_gen_clkroot_anchor.sv
// Anchor cell marking the generated-clock root so timing constraints can attach to it.
module clkroot_anchor (
    input  logic i,
    output logic z
);
    assign z = i;
endmodule

// File: rtl/clkdiv_gen.sv
// Programmable integer clock divider with glitch-free period-boundary updates.
// Optional completed-period debug counter enabled by defining CLKDIV_DBG_COUNT_EN.
module clkdiv_gen
    import clkdiv_gen_pkg::*;
#(
    parameter int W       = 32'd8,
    parameter int DIV_RST = 32'd4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    clkdiv_gen_if.slave  cfg_if,
    output logic         clk_div_o,
    output logic         tick_o,
    output logic         busy_o,
    output logic [15:0]  dbg_periods_o
);

    localparam logic [W-1:0] MIN_DIV = W'(CLKDIV_MIN_DIV);
    localparam logic [W-1:0] RST_DIV = W'(DIV_RST);

    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        logic [W-1:0] r;
        if (d < MIN_DIV) begin
            r = MIN_DIV;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // High phase is floor(N/2) cycles; the counter reloads with length-1.
    function automatic logic [W-1:0] hi_reload(input logic [W-1:0] n);
        return (n >> 1) - W'(1);
    endfunction

    function automatic logic [W-1:0] lo_reload(input logic [W-1:0] n);
        return n - (n >> 1) - W'(1);
    endfunction

    clkdiv_state_e state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  div_q, div_d;
    logic [W-1:0]  pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          clk_div_q, clk_div_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;
    logic [W-1:0]  div_eff_s;
    logic          accept_s;

    assign accept_s = cfg_if.cfg_valid & rdy_q;

    // Next-state, phase counter and divisor/pending bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_vld_d = pend_vld_q;
        clk_div_d  = clk_div_q;
        tick_d     = 1'b0;
        if (pend_vld_q) begin
            div_eff_s = pend_q;
        end else begin
            div_eff_s = div_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A pending divisor is applied on the next edge whether or not we start.
                div_d      = div_eff_s;
                pend_vld_d = 1'b0;
                clk_div_d  = 1'b0;
                if (en_i) begin
                    state_d   = ST_HIGH;
                    clk_div_d = 1'b1;
                    tick_d    = 1'b1;
                    cnt_d     = hi_reload(div_eff_s);
                end else begin
                    cnt_d     = {W{1'b0}};
                end
            end
            ST_HIGH: begin
                if (cnt_q == {W{1'b0}}) begin
                    state_d   = ST_LOW;
                    clk_div_d = 1'b0;
                    cnt_d     = lo_reload(div_q);
                end else begin
                    cnt_d     = cnt_q - W'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q == {W{1'b0}}) begin
                    if (en_i) begin
                        state_d    = ST_HIGH;
                        clk_div_d  = 1'b1;
                        tick_d     = 1'b1;
                        div_d      = div_eff_s;
                        pend_vld_d = 1'b0;
                        cnt_d      = hi_reload(div_eff_s);
                    end else begin
                        state_d    = ST_IDLE;
                        clk_div_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_div_d = 1'b0;
                cnt_d     = {W{1'b0}};
            end
        endcase

        // Accept only happens with no pending value, so it never races the clear above.
        if (accept_s) begin
            pend_d     = clamp_div(cfg_if.cfg_div);
            pend_vld_d = 1'b1;
        end else begin
            pend_d     = pend_q;
        end

        busy_d = (state_d != ST_IDLE);
        rdy_d  = ~pend_vld_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {W{1'b0}};
            div_q      <= RST_DIV;
            pend_q     <= RST_DIV;
            pend_vld_q <= 1'b0;
            clk_div_q  <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_div_q  <= clk_div_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef CLKDIV_DBG_COUNT_EN
    logic        per_done_s;
    logic [15:0] dbg_q;

    assign per_done_s = (state_q == ST_LOW) && (cnt_q == {W{1'b0}});

    // Completed-period counter, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_q <= 16'h0000;
        end else if (per_done_s) begin
            dbg_q <= sat_inc16(dbg_q);
        end else begin
            dbg_q <= dbg_q;
        end
    end

    assign dbg_periods_o = dbg_q;
`else
    assign dbg_periods_o = 16'h0000;
`endif

    assign cfg_if.cfg_ready = rdy_q;
    assign tick_o           = tick_q;
    assign busy_o           = busy_q;

    clkroot_anchor u_clkroot_anchor (
        .i (clk_div_q),
        .z (clk_div_o)
    );

endmodule

// File: tb/tb_clkdiv_gen.sv
// Directed self-checking bench for clkdiv_gen (optionally built with CLKDIV_DBG_COUNT_EN).
module tb_clkdiv_gen;

    localparam int W = 8;
`ifdef CLKDIV_DBG_COUNT_EN
    localparam int DBG_EXP = 10;
`else
    localparam int DBG_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clk_div, tick, busy;
    logic [15:0] dbg;
    int          n_pass = 0;
    int          n_total = 0;

    clkdiv_gen_if #(.W(W)) cfg_if ();

    always #5 clk = ~clk;

    clkdiv_gen #(.W(W), .DIV_RST(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .cfg_if        (cfg_if.slave),
        .clk_div_o     (clk_div),
        .tick_o        (tick),
        .busy_o        (busy),
        .dbg_periods_o (dbg)
    );

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starts on a rise cycle; counts high/low lengths and tick anomalies up to the next rise.
    task automatic measure(output int hi, output int lo, output int xt, output bit ok);
        hi = 1; lo = 0; xt = 0; ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (clk_div === 1'b1 && lo == 0) begin
                hi++;
                if (tick !== 1'b0) xt++;
            end else if (clk_div === 1'b1) begin
                if (tick !== 1'b1) xt++;
                ok = 1'b1;
                break;
            end else begin
                lo++;
                if (tick !== 1'b0) xt++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = 8'd0;
        repeat (2) @(negedge clk);
        n_total++; if ({clk_div, tick, busy} !== 3'b000) $display("FAIL reset_outs: got %b want 000", {clk_div, tick, busy}); else n_pass++;
        n_total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_if.cfg_ready); else n_pass++;
        n_total++; if (dbg !== 16'd0) $display("FAIL reset_dbg: got %0d want 0", dbg); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if ({clk_div, tick, busy} !== 3'b111) $display("FAIL first_rise: got %b want 111", {clk_div, tick, busy}); else n_pass++;
    endtask

    task automatic test_startup();
        int hi, lo, xt; bit ok;
        for (int p = 0; p < 2; p++) begin
            measure(hi, lo, xt, ok);
            n_total++; if (!ok || hi != 2 || lo != 2 || xt != 0)
                $display("FAIL div4_period%0d: got ok=%0d H=%0d L=%0d xt=%0d want ok=1 H=2 L=2 xt=0", p, ok, hi, lo, xt);
            else n_pass++;
        end
    endtask

    task automatic test_reconfig();
        int hi, lo, xt; bit ok;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd7;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        n_total++; if ({clk_div, cfg_if.cfg_ready} !== 2'b10) $display("FAIL cfg_mid_high: got clk/rdy=%b want 10", {clk_div, cfg_if.cfg_ready}); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++; if ({clk_div, cfg_if.cfg_ready} !== 2'b00) $display("FAIL cfg_low%0d: got clk/rdy=%b want 00", i, {clk_div, cfg_if.cfg_ready}); else n_pass++;
        end
        @(negedge clk);
        n_total++; if ({clk_div, tick, cfg_if.cfg_ready} !== 3'b111) $display("FAIL cfg_boundary: got clk/tick/rdy=%b want 111", {clk_div, tick, cfg_if.cfg_ready}); else n_pass++;
        measure(hi, lo, xt, ok);
        n_total++; if (!ok || hi != 3 || lo != 4 || xt != 0)
            $display("FAIL div7_period: got ok=%0d H=%0d L=%0d xt=%0d want ok=1 H=3 L=4 xt=0", ok, hi, lo, xt);
        else n_pass++;
    endtask

    task automatic test_stop();
        logic [4:0] exp_clk, exp_busy;
        int ticks, highs; bit ok;
        exp_clk  = 5'b10000;
        exp_busy = 5'b11110;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd5;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        wait_rise(ok);
        n_total++; if (!ok) $display("FAIL stop_rise: got timeout want rise"); else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++; if (clk_div !== exp_clk[4-i] || busy !== exp_busy[4-i])
                $display("FAIL stop_cyc%0d: got clk=%b busy=%b want clk=%b busy=%b", i, clk_div, busy, exp_clk[4-i], exp_busy[4-i]);
            else n_pass++;
        end
        ticks = 0; highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick !== 1'b0) ticks++;
            if (clk_div !== 1'b0 || busy !== 1'b0) highs++;
        end
        n_total++; if (ticks != 0 || highs != 0) $display("FAIL stop_idle: got ticks=%0d active=%0d want 0 0", ticks, highs); else n_pass++;
    endtask

    task automatic test_clamp();
        logic [7:0] divs [3];
        int exp_h [3];
        int exp_l [3];
        int hi, lo, xt; bit ok;
        divs = '{8'd0, 8'd1, 8'd255};
        exp_h = '{1, 1, 127};
        exp_l = '{1, 1, 128};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = divs[k];
            @(negedge clk);
            cfg_if.cfg_valid = 1'b0;
            n_total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL clamp%0d_pend: got rdy=%b want 0", k, cfg_if.cfg_ready); else n_pass++;
            @(negedge clk);
            n_total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL clamp%0d_idle_apply: got rdy=%b want 1", k, cfg_if.cfg_ready); else n_pass++;
            en = 1'b1;
            wait_rise(ok);
            measure(hi, lo, xt, ok);
            n_total++; if (!ok || hi != exp_h[k] || lo != exp_l[k] || xt != 0)
                $display("FAIL clamp%0d_period: got ok=%0d H=%0d L=%0d xt=%0d want ok=1 H=%0d L=%0d xt=0", k, ok, hi, lo, xt, exp_h[k], exp_l[k]);
            else n_pass++;
            en = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (busy === 1'b0) begin ok = 1'b1; break; end
            end
            n_total++; if (!ok) $display("FAIL clamp%0d_idle: got busy=%b want 0", k, busy); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int hi, lo, xt; bit ok;
        en = 1'b1;
        wait_rise(ok);
        repeat (10) @(negedge clk);
        n_total++; if (clk_div !== 1'b1) $display("FAIL arst_pre: got clk=%b want 1", clk_div); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if ({clk_div, tick, busy, cfg_if.cfg_ready} !== 4'b0001)
            $display("FAIL arst_now: got clk/tick/busy/rdy=%b want 0001", {clk_div, tick, busy, cfg_if.cfg_ready});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if ({clk_div, tick} !== 2'b11) $display("FAIL arst_restart: got clk/tick=%b want 11", {clk_div, tick}); else n_pass++;
        measure(hi, lo, xt, ok);
        n_total++; if (!ok || hi != 2 || lo != 2 || xt != 0)
            $display("FAIL arst_div_rst: got ok=%0d H=%0d L=%0d xt=%0d want ok=1 H=2 L=2 xt=0", ok, hi, lo, xt);
        else n_pass++;
    endtask

    task automatic test_dbg_count();
        bit ok;
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_rise(ok);
        for (int p = 0; p < 10; p++) wait_rise(ok);
        n_total++; if (!ok || dbg !== 16'(DBG_EXP)) $display("FAIL dbg_periods: got %0d want %0d", dbg, DBG_EXP); else n_pass++;
        en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_startup();
        test_reconfig();
        test_stop();
        test_clamp();
        test_async_reset();
        test_dbg_count();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
